// File: rtl/ghost_spawn_scheduler.sv
// Ghost spawn scheduler: timed round-robin spawn requests into NUM_SLOTS ghost slots.
// Optional macro SPAWN_RAMP_EN shrinks the spawn interval after every completed spawn.
module ghost_spawn_scheduler #(
    parameter int NUM_SLOTS     = 4,
    parameter int INIT_INTERVAL = 100000000,
    parameter int MIN_INTERVAL  = 25000000,
    parameter int STEP          = 5000000,
    parameter int X_MIN         = 64
) (
    input  logic                 clk,
    input  logic                 hard_reset,
    input  logic                 game_reset,
    input  logic                 game_en,
    input  logic [NUM_SLOTS-1:0] slot_active,
    input  logic [NUM_SLOTS-1:0] spawn_ack,
    output logic [NUM_SLOTS-1:0] spawn_req,
    output logic [9:0]           spawn_x,
    output logic [7:0]           spawn_count
);

    localparam int          SEL_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [31:0] INIT_L  = 32'(INIT_INTERVAL);
    localparam logic [31:0] MIN_L   = 32'(MIN_INTERVAL);
    localparam logic [31:0] STEP_L  = 32'(STEP);
    localparam logic [9:0]  X_MIN_L = 10'(X_MIN);
    localparam logic [9:0]  LFSR_SEED = 10'h2A5;

`ifdef SPAWN_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SELECT,
        S_REQ
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          timer_q, timer_d;
    logic [31:0]          interval_q, interval_d;
    logic [SEL_W-1:0]     rr_q, rr_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [NUM_SLOTS-1:0] req_q, req_d;
    logic [9:0]           x_q, x_d;
    logic [7:0]           count_q, count_d;
    logic [9:0]           lfsr_q, lfsr_d;

    logic [NUM_SLOTS-1:0] free_slots;
    logic [SEL_W-1:0]     pick;
    logic [31:0]          ramp_interval;
    logic [31:0]          next_interval;
    logic [SEL_W-1:0]     rr_after_sel;
    logic                 ack_hit;

    assign free_slots = ~slot_active;
    assign ack_hit    = |(spawn_ack & req_q);

    // Scan downward so the last hit written is the nearest free slot at/after rr_q.
    always_comb begin
        int idx;
        idx  = 0;
        pick = rr_q;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_SLOTS) begin
                idx = idx - NUM_SLOTS;
            end
            if (free_slots[SEL_W'(idx)]) begin
                pick = SEL_W'(idx);
            end
        end
    end

    assign ramp_interval = (interval_q > MIN_L + STEP_L) ? (interval_q - STEP_L) : MIN_L;
    assign next_interval = RAMP_EN ? ramp_interval : interval_q;
    assign rr_after_sel  = (sel_q == SEL_W'(NUM_SLOTS - 1)) ? '0 : (sel_q + SEL_W'(1));

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        interval_d = interval_q;
        rr_d       = rr_q;
        sel_d      = sel_q;
        req_d      = req_q;
        x_d        = x_q;
        count_d    = count_q;
        lfsr_d     = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

        if (game_reset) begin
            state_d    = S_IDLE;
            timer_d    = '0;
            interval_d = INIT_L;
            rr_d       = '0;
            req_d      = '0;
            x_d        = '0;
            count_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (game_en) begin
                        state_d = S_WAIT;
                        timer_d = interval_q - 32'd1;
                    end
                end
                S_WAIT: begin
                    if (timer_q != 32'd0) begin
                        timer_d = timer_q - 32'd1;
                    end else begin
                        state_d = S_SELECT;
                    end
                end
                S_SELECT: begin
                    // With every slot busy the spawn stays pending here; the timer is not reloaded.
                    if (game_en && (|free_slots)) begin
                        sel_d   = pick;
                        req_d   = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << pick;
                        x_d     = X_MIN_L + {1'b0, lfsr_q[8:0]};
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    if (ack_hit) begin
                        req_d      = '0;
                        rr_d       = rr_after_sel;
                        count_d    = (count_q == 8'hFF) ? count_q : (count_q + 8'd1);
                        interval_d = next_interval;
                        timer_d    = next_interval - 32'd1;
                        state_d    = S_WAIT;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // Leaving gameplay drops any request but a same-cycle ack still completes above.
            if (!game_en) begin
                state_d = S_IDLE;
                req_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge hard_reset) begin
        if (hard_reset) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            interval_q <= INIT_L;
            rr_q       <= '0;
            sel_q      <= '0;
            req_q      <= '0;
            x_q        <= '0;
            count_q    <= '0;
            lfsr_q     <= LFSR_SEED;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            interval_q <= interval_d;
            rr_q       <= rr_d;
            sel_q      <= sel_d;
            req_q      <= req_d;
            x_q        <= x_d;
            count_q    <= count_d;
            lfsr_q     <= lfsr_d;
        end
    end

    assign spawn_req   = req_q;
    assign spawn_x     = x_q;
    assign spawn_count = count_q;

endmodule

// File: tb/tb_ghost_spawn_scheduler.sv
// Directed bench for ghost_spawn_scheduler with a scoreboard of expected requests and latencies.
module tb_ghost_spawn_scheduler;

    logic       clk;
    logic       hard_reset;
    logic       game_reset;
    logic       game_en;
    logic [3:0] slot_active;
    logic [3:0] spawn_ack;
    logic [3:0] spawn_req;
    logic [9:0] spawn_x;
    logic [7:0] spawn_count;

    ghost_spawn_scheduler #(
        .NUM_SLOTS    (4),
        .INIT_INTERVAL(10),
        .MIN_INTERVAL (4),
        .STEP         (3),
        .X_MIN        (64)
    ) dut (
        .clk        (clk),
        .hard_reset (hard_reset),
        .game_reset (game_reset),
        .game_en    (game_en),
        .slot_active(slot_active),
        .spawn_ack  (spawn_ack),
        .spawn_req  (spawn_req),
        .spawn_x    (spawn_x),
        .spawn_count(spawn_count)
    );

    typedef struct {
        logic [3:0] req;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   model_rr;
    int   model_cnt;
    int   model_int;
    int   cur_sel;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int sel, input int lat);
        exp_t e;
        e.req = 4'b0001 << sel;
        e.lat = lat;
        sb.push_back(e);
        cur_sel = sel;
    endtask

    // Pops the next expected request and waits (bounded) for the DUT to raise one.
    task automatic wait_spawn(input string tag, input int t0);
        exp_t e;
        int   lat;
        e   = sb.pop_front();
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (spawn_req !== 4'b0000) begin
                lat = cyc - t0;
                break;
            end
        end
        chk({tag, "_req"}, 32'(spawn_req), 32'(e.req));
        chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
        $display("spawn %s: req=%b x=%0d lat=%0d count=%0d", tag, spawn_req, spawn_x, lat, spawn_count);
    endtask

    task automatic model_complete(input int sel);
        model_cnt = (model_cnt == 255) ? 255 : model_cnt + 1;
        model_rr  = (sel + 1) % 4;
`ifdef SPAWN_RAMP_EN
        model_int = (model_int > 7) ? model_int - 3 : 4;
`endif
    endtask

    task automatic complete(input string tag, input int sel, output int t0);
        spawn_ack = 4'b0001 << sel;
        t0 = cyc;
        @(negedge clk);
        spawn_ack = 4'b0000;
        model_complete(sel);
        chk({tag, "_req_clr"}, 32'(spawn_req), 32'd0);
        chk({tag, "_count"}, 32'(spawn_count), 32'(model_cnt));
    endtask

    initial begin
        int         t0;
        int         lat;
        logic [9:0] x_held;
        logic [3:0] r_held;

        hard_reset  = 1'b1;
        game_reset  = 1'b0;
        game_en     = 1'b0;
        slot_active = 4'b0000;
        spawn_ack   = 4'b0000;
        model_rr    = 0;
        model_cnt   = 0;
        model_int   = 10;
        cur_sel     = 0;
        t0          = 0;

        repeat (3) @(negedge clk);
        chk("rst_req", 32'(spawn_req), 32'd0);
        chk("rst_x", 32'(spawn_x), 32'd0);
        chk("rst_count", 32'(spawn_count), 32'd0);
        hard_reset = 1'b0;
        @(negedge clk);

        // 1: first spawn INIT_INTERVAL+2 after game_en, ack three cycles later
        game_en = 1'b1;
        t0 = cyc;
        push_exp(0, 12);
        wait_spawn("t1_first", t0);
        x_held = spawn_x;
        chk("t1_x_range", 32'((spawn_x >= 10'd64) && (spawn_x <= 10'd575)), 32'd1);
        repeat (3) @(negedge clk);
        chk("t1_x_held", 32'(spawn_x), 32'(x_held));
        chk("t1_req_held", 32'(spawn_req), 32'(4'b0001));
        complete("t1_ack", cur_sel, t0);
        push_exp(model_rr, model_int + 2);
        wait_spawn("t1_second", t0);

        // 2: immediate acks, gap equals interval+2 (ramps when enabled)
        for (int k = 0; k < 3; k++) begin
            complete("t2_ack", cur_sel, t0);
            push_exp(model_rr, model_int + 2);
            wait_spawn("t2_gap", t0);
        end

        // 3: all slots busy at expiry, then release slot 2
        complete("t3_ack", cur_sel, t0);
        slot_active = 4'b1111;
        repeat (model_int + 8) @(negedge clk);
        chk("t3_blocked", 32'(spawn_req), 32'd0);
        slot_active = 4'b1011;
        t0  = cyc;
        lat = -1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (spawn_req !== 4'b0000) begin
                lat = cyc - t0;
                break;
            end
        end
        chk("t3_req", 32'(spawn_req), 32'(4'b0100));
        chk("t3_lat_ok", 32'((lat >= 1) && (lat <= 2)), 32'd1);
        chk("t3_x_range", 32'((spawn_x >= 10'd64) && (spawn_x <= 10'd575)), 32'd1);
        x_held = spawn_x;
        r_held = spawn_req;
        repeat (3) @(negedge clk);
        chk("t3_x_held", 32'(spawn_x), 32'(x_held));
        chk("t3_req_held", 32'(spawn_req), 32'(r_held));
        $display("spawn t3_release: req=%b x=%0d lat=%0d", spawn_req, spawn_x, lat);

        // 4: rr_ptr=3 with slot 3 busy wraps to slot 0; ack on wrong bit ignored
        slot_active = 4'b1000;
        complete("t4_ack2", 2, t0);
        push_exp(0, model_int + 2);
        wait_spawn("t4_wrap", t0);
        spawn_ack = 4'b0010;
        @(negedge clk);
        spawn_ack = 4'b0000;
        chk("t4_wrong_ack_req", 32'(spawn_req), 32'(4'b0001));
        chk("t4_wrong_ack_count", 32'(spawn_count), 32'(model_cnt));
        slot_active = 4'b0000;
        complete("t4_ack0", cur_sel, t0);
        push_exp(model_rr, model_int + 2);
        wait_spawn("t4_next", t0);

        // 5: game_en falls in REQ without ack, then re-rises
        game_en = 1'b0;
        @(negedge clk);
        chk("t5_req_drop", 32'(spawn_req), 32'd0);
        chk("t5_count_kept", 32'(spawn_count), 32'(model_cnt));
        repeat (3) @(negedge clk);
        chk("t5_idle_req", 32'(spawn_req), 32'd0);
        game_en = 1'b1;
        t0 = cyc;
        push_exp(model_rr, model_int + 2);
        wait_spawn("t5_rerise", t0);

        // 6: game_reset with coincident ack, then saturate the counter
        game_reset = 1'b1;
        spawn_ack  = 4'b0001 << cur_sel;
        t0 = cyc;
        @(negedge clk);
        game_reset = 1'b0;
        spawn_ack  = 4'b0000;
        model_rr   = 0;
        model_cnt  = 0;
        model_int  = 10;
        chk("t6_count", 32'(spawn_count), 32'd0);
        chk("t6_req", 32'(spawn_req), 32'd0);
        chk("t6_x", 32'(spawn_x), 32'd0);
        push_exp(0, 13);
        wait_spawn("t6_after_reset", t0);
        for (int i = 0; i < 256; i++) begin
            complete("t6_sat", cur_sel, t0);
            if (i < 255) begin
                push_exp(model_rr, model_int + 2);
                wait_spawn("t6_loop", t0);
            end
        end
        chk("t6_count_sat", 32'(spawn_count), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
